// File: rtl/serdesphy_ana_pll_nco_if.sv
// Control/status bundle for the PLL numerically-controlled oscillator.
// The driver of enable/vco_control uses master; the NCO itself uses slave.
interface serdesphy_ana_pll_nco_if #(
    parameter int CTRL_W = 8
);
    logic              enable;
    logic [CTRL_W-1:0] vco_control;
    logic              vco_out;
    logic              vco_ready;
    logic              vco_busy;

    modport master (
        output enable,
        output vco_control,
        input  vco_out,
        input  vco_ready,
        input  vco_busy
    );

    modport slave (
        input  enable,
        input  vco_control,
        output vco_out,
        output vco_ready,
        output vco_busy
    );
endinterface

// File: rtl/serdesphy_ana_pll_nco.sv
// Phase-accumulator oscillator with OFF/SETTLE/RUN control.
// Large control steps trigger a re-settle while the phase keeps running.
module serdesphy_ana_pll_nco #(
    parameter int          CTRL_W        = 8,
    parameter int          ACC_W         = 16,
    parameter int unsigned BASE_INC      = 32'h2000,
    parameter int unsigned GAIN          = 4,
    parameter int          SETTLE_CYCLES = 64,
    parameter int unsigned STEP_THRESH   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    serdesphy_ana_pll_nco_if.slave   nco
);
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [ACC_W-1:0]  BASE_W   = ACC_W'(BASE_INC);
    localparam logic [ACC_W-1:0]  GAIN_W   = ACC_W'(GAIN);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CTRL_W:0]   THRESH_W = (CTRL_W + 1)'(STEP_THRESH);
    localparam logic [CTRL_W:0]   ONE_W    = (CTRL_W + 1)'(1);

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    state_t              r_state;
    logic [ACC_W-1:0]    r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic [CTRL_W-1:0]   r_ctrl_q;
    logic [CTRL_W-1:0]   r_ctrl_prev;
    logic                r_out;
    logic                r_ready;
    logic                r_busy;

    logic [ACC_W-1:0]    w_inc;
    logic [CTRL_W:0]     w_diff;
    logic [CTRL_W:0]     w_mag;
    logic                w_retune;

    assign w_inc = BASE_W + ACC_W'(r_ctrl_q) * GAIN_W;

    // One extra bit keeps a 0 <-> max transition a full-scale step, not a wrap.
    assign w_diff   = {1'b0, r_ctrl_q} - {1'b0, r_ctrl_prev};
    assign w_mag    = w_diff[CTRL_W] ? (~w_diff + ONE_W) : w_diff;
    assign w_retune = (w_mag > THRESH_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_OFF;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ctrl_q    <= '0;
            r_ctrl_prev <= '0;
            r_out       <= 1'b0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_ctrl_q    <= nco.vco_control;
            r_ctrl_prev <= r_ctrl_q;

            // Status flags follow the state register one cycle behind.
            r_out   <= (r_state != ST_OFF) & r_acc[ACC_W-1];
            r_ready <= (r_state == ST_RUN);
            r_busy  <= (r_state == ST_SETTLE);

            if (!nco.enable) begin
                r_state <= ST_OFF;
                r_acc   <= '0;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    ST_OFF: begin
                        r_state <= ST_SETTLE;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end
                    ST_SETTLE: begin
                        r_acc <= r_acc + w_inc;
                        if (r_cnt == CNT_LAST) begin
                            r_state <= ST_RUN;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    ST_RUN: begin
                        r_acc <= r_acc + w_inc;
                        if (w_retune) begin
                            r_state <= ST_SETTLE;
                            r_cnt   <= '0;
                        end
                    end
                    default: begin
                        r_state <= ST_OFF;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign nco.vco_out   = r_out;
    assign nco.vco_ready = r_ready;
    assign nco.vco_busy  = r_busy;
endmodule

// File: tb/tb_serdesphy_ana_pll_nco.sv
// Scoreboard bench: stimulus queues cycle-tagged expectations,
// a negedge monitor pops and compares them against both NCO instances.
module tb_serdesphy_ana_pll_nco;
    localparam int K_SIG   = 0;
    localparam int K_MARK  = 1;
    localparam int K_RISES = 2;
    localparam int K_HIGHS = 3;

    typedef struct {
        int         cyc;
        int         dut;
        int         kind;
        logic [2:0] exp;
        logic [2:0] mask;
        int         lo;
        int         hi;
        string      name;
    } item_t;

    logic clk = 1'b0;
    logic rst_n;
    int   pcnt = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   excl_viol = 0;
    item_t sb[$];

    int   rise_c[2];
    int   high_c[2];
    int   snap_r[2];
    int   snap_h[2];
    logic prev_out[2];

    serdesphy_ana_pll_nco_if #(.CTRL_W(8)) if1 ();
    serdesphy_ana_pll_nco_if #(.CTRL_W(6)) if2 ();

    serdesphy_ana_pll_nco u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .nco   (if1)
    );

    serdesphy_ana_pll_nco #(
        .CTRL_W        (6),
        .ACC_W         (12),
        .BASE_INC      (32'hF80),
        .GAIN          (4),
        .SETTLE_CYCLES (1),
        .STEP_THRESH   (8)
    ) u_dut_small (
        .clk   (clk),
        .rst_n (rst_n),
        .nco   (if2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) pcnt <= pcnt + 1;

    task automatic chk(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, pcnt);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // exp/mask bit order is {vco_out, vco_ready, vco_busy}
    task automatic expect_sig(input int d, input int dut, input string name,
                              input logic [2:0] exp, input logic [2:0] mask);
        item_t it;
        it.cyc = pcnt + d; it.dut = dut; it.kind = K_SIG;
        it.exp = exp; it.mask = mask; it.lo = 0; it.hi = 0; it.name = name;
        sb.push_back(it);
    endtask

    task automatic expect_win(input int d, input int len, input int dut, input int kind,
                              input string name, input int lo, input int hi);
        item_t it;
        it.cyc = pcnt + d; it.dut = dut; it.kind = K_MARK;
        it.exp = '0; it.mask = '0; it.lo = 0; it.hi = 0; it.name = name;
        sb.push_back(it);
        it.cyc = pcnt + d + len; it.kind = kind; it.lo = lo; it.hi = hi;
        sb.push_back(it);
    endtask

    // Monitor
    initial begin
        logic [2:0] smp [2];
        item_t it;
        for (int k = 0; k < 2; k++) begin
            rise_c[k] = 0; high_c[k] = 0; snap_r[k] = 0; snap_h[k] = 0; prev_out[k] = 1'b0;
        end
        forever begin
            @(negedge clk);
            smp[0] = {if1.vco_out, if1.vco_ready, if1.vco_busy};
            smp[1] = {if2.vco_out, if2.vco_ready, if2.vco_busy};
            for (int k = 0; k < 2; k++) begin
                if (smp[k][2] && !prev_out[k]) rise_c[k]++;
                if (smp[k][2]) high_c[k]++;
                prev_out[k] = smp[k][2];
                if (smp[k][1] && smp[k][0]) excl_viol++;
            end
            for (int i = 0; i < sb.size(); ) begin
                if (sb[i].cyc == pcnt) begin
                    it = sb[i];
                    sb.delete(i);
                    case (it.kind)
                        K_SIG:   chk(it.name, int'(smp[it.dut] & it.mask),
                                     int'(it.exp & it.mask), int'(it.exp & it.mask));
                        K_MARK: begin
                            snap_r[it.dut] = rise_c[it.dut];
                            snap_h[it.dut] = high_c[it.dut];
                        end
                        K_RISES: chk(it.name, rise_c[it.dut] - snap_r[it.dut], it.lo, it.hi);
                        default: chk(it.name, high_c[it.dut] - snap_h[it.dut], it.lo, it.hi);
                    endcase
                end else begin
                    i++;
                end
            end
        end
    end

    // Stimulus
    initial begin
        int guard;
        rst_n = 1'b0;
        if1.enable = 1'b0; if1.vco_control = 8'd0;
        if2.enable = 1'b0; if2.vco_control = 6'd0;
        tick(3);
        expect_sig(0, 0, "reset_state", 3'b000, 3'b111);
        expect_sig(0, 1, "reset_state_small", 3'b000, 3'b111);
        tick(1);

        // Startup at control 0: busy 64 cycles, ready at +66, period 8 / 50% duty
        rst_n = 1'b1;
        if1.enable = 1'b1;
        expect_sig(1,  0, "start_idle",      3'b000, 3'b011);
        expect_sig(2,  0, "start_busy",      3'b001, 3'b011);
        expect_sig(5,  0, "start_out_low",   3'b001, 3'b111);
        expect_sig(6,  0, "start_out_high",  3'b101, 3'b111);
        expect_sig(65, 0, "start_busy_last", 3'b001, 3'b011);
        expect_sig(66, 0, "start_ready",     3'b010, 3'b011);
        expect_sig(100, 0, "ready_holds",    3'b010, 3'b011);
        expect_win(10, 80, 0, K_RISES, "rises_ctrl0", 10, 10);
        expect_win(10, 80, 0, K_HIGHS, "highs_ctrl0", 40, 40);
        tick(110);

        // Full-scale step 0 -> 255: retune, then average period ~7.12 cycles
        if1.vco_control = 8'd255;
        expect_sig(2,  0, "ret255_before", 3'b010, 3'b011);
        expect_sig(3,  0, "ret255_busy",   3'b001, 3'b011);
        expect_sig(66, 0, "ret255_still",  3'b001, 3'b011);
        expect_sig(67, 0, "ret255_ready",  3'b010, 3'b011);
        expect_win(4, 1024, 0, K_RISES, "rises_ctrl255", 143, 145);
        tick(1030);

        if1.vco_control = 8'd100;
        tick(80);

        // Step of 9 retunes
        if1.vco_control = 8'd109;
        expect_sig(2,  0, "step9_before", 3'b010, 3'b011);
        expect_sig(3,  0, "step9_drop",   3'b001, 3'b011);
        expect_sig(67, 0, "step9_back",   3'b010, 3'b011);
        tick(80);
        if1.vco_control = 8'd100;
        tick(80);

        // Step of 8 stays in RUN; edge count spans the step
        expect_win(0, 512, 0, K_RISES, "rises_100_108", 66, 68);
        tick(256);
        if1.vco_control = 8'd108;
        expect_sig(3,  0, "step8_hold",  3'b010, 3'b011);
        expect_sig(10, 0, "step8_hold2", 3'b010, 3'b011);
        tick(260);

        // Disable in RUN
        if1.enable = 1'b0;
        expect_sig(1, 0, "dis_run_last", 3'b010, 3'b011);
        expect_sig(2, 0, "dis_run_off",  3'b000, 3'b111);
        tick(3);

        // Disable at settle cycle 30, then full re-settle
        if1.enable = 1'b1;
        tick(30);
        if1.enable = 1'b0;
        expect_sig(1, 0, "dis_settle_busy", 3'b001, 3'b011);
        expect_sig(2, 0, "dis_settle_off",  3'b000, 3'b111);
        expect_sig(3, 0, "dis_settle_off2", 3'b000, 3'b111);
        tick(4);
        if1.enable = 1'b1;
        expect_sig(65, 0, "reen_busy",  3'b001, 3'b011);
        expect_sig(66, 0, "reen_ready", 3'b010, 3'b011);
        tick(80);

        // Asynchronous reset between edges in RUN
        expect_sig(0, 0, "pre_rst_ready", 3'b010, 3'b011);
        tick(1);
        rst_n = 1'b0;
        expect_sig(0, 0, "async_rst", 3'b000, 3'b111);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        tick(1);
        expect_sig(1, 0, "post_rst_busy", 3'b001, 3'b011);
        tick(70);

        // Small instance: 1-cycle settle, increment 0xF80+63*4 wraps to 0x07C
        if2.enable = 1'b1;
        if2.vco_control = 6'd63;
        expect_sig(1,  1, "sw_idle",       3'b000, 3'b011);
        expect_sig(2,  1, "sw_busy",       3'b001, 3'b011);
        expect_sig(3,  1, "sw_ready",      3'b010, 3'b011);
        expect_sig(20, 1, "sw_ready_hold", 3'b010, 3'b011);
        expect_win(5, 1024, 1, K_RISES, "sw_rises_wrap", 31, 31);
        tick(1040);

        guard = 0;
        while (sb.size() != 0 && guard < 2000) begin
            tick(1);
            guard++;
        end
        while (sb.size() != 0) begin
            chk({"missed_", sb[0].name}, 0, 1, 1);
            sb.delete(0);
        end
        chk("ready_busy_exclusive", excl_viol, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
